// File: rtl/instruction_fetch.sv
// Instruction fetch stage: owns the PC, runs the req/ack handshake with
// instruction memory and hands each fetched word to the decoder as a
// one-clock pulse, with NOP on every other edge.
// Optional build macro FETCH_TIMEOUT_EN adds an ack timeout that drops the
// request, raises sticky fetch_error and parks the stage in ERROR until reset.
module instruction_fetch #(
  parameter int unsigned           ADDR_WIDTH     = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
  parameter logic [ADDR_WIDTH-1:0] PC_STEP        = ADDR_WIDTH'(1),
  parameter int unsigned           TIMEOUT_CYCLES = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [31:0]           imem_rdata,
  input  logic                  branch_taken,
  input  logic [ADDR_WIDTH-1:0] branch_target,
  input  logic                  stall,
  output logic [31:0]           instruction,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  output logic                  fetch_error
);

  localparam int unsigned DataW = 32;

  // A zero timeout would make the stage fault before any ack could arrive.
  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("instruction_fetch: TIMEOUT_CYCLES must be nonzero");
  end

`ifdef FETCH_TIMEOUT_EN
  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HOLD, ST_ERROR} state_e;
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
`else
  typedef enum logic [1:0] {ST_FETCH, ST_WAIT, ST_HOLD} state_e;
`endif

  state_e                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic                    req_q, req_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DataW-1:0]        instr_q, instr_d;
  logic [ADDR_WIDTH-1:0]   ipc_q, ipc_d;
  logic                    valid_q, valid_d;
  logic                    squash_q, squash_d;
  logic [ADDR_WIDTH-1:0]   pending_q, pending_d;
  logic [DataW-1:0]        hold_q, hold_d;
`ifdef FETCH_TIMEOUT_EN
  logic                    err_q, err_d;
  logic [CntW-1:0]         cnt_q, cnt_d;
`endif

  // State and datapath registers; reset aborts any in-flight transaction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      pc_q      <= RESET_PC;
      req_q     <= 1'b0;
      addr_q    <= RESET_PC;
      instr_q   <= '0;
      ipc_q     <= RESET_PC;
      valid_q   <= 1'b0;
      squash_q  <= 1'b0;
      pending_q <= '0;
      hold_q    <= '0;
`ifdef FETCH_TIMEOUT_EN
      err_q     <= 1'b0;
      cnt_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_q     <= req_d;
      addr_q    <= addr_d;
      instr_q   <= instr_d;
      ipc_q     <= ipc_d;
      valid_q   <= valid_d;
      squash_q  <= squash_d;
      pending_q <= pending_d;
      hold_q    <= hold_d;
`ifdef FETCH_TIMEOUT_EN
      err_q     <= err_d;
      cnt_q     <= cnt_d;
`endif
    end
  end

  // Next-state logic; instruction/instr_valid default to NOP every edge.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_d     = req_q;
    addr_d    = addr_q;
    instr_d   = '0;
    ipc_d     = ipc_q;
    valid_d   = 1'b0;
    squash_d  = squash_q;
    pending_d = pending_q;
    hold_d    = hold_q;
`ifdef FETCH_TIMEOUT_EN
    err_d     = err_q;
    cnt_d     = cnt_q;
`endif

    case (state_q)
      ST_FETCH: begin
        if (branch_taken) begin
          pc_d = branch_target;
        end else begin
          req_d   = 1'b1;
          addr_d  = pc_q;
          state_d = ST_WAIT;
`ifdef FETCH_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end

      ST_WAIT: begin
        if (imem_ack) begin
          req_d = 1'b0;
          if (branch_taken) begin
            pc_d     = branch_target;
            squash_d = 1'b0;
            state_d  = ST_FETCH;
          end else if (squash_q) begin
            pc_d     = pending_q;
            squash_d = 1'b0;
            state_d  = ST_FETCH;
          end else if (stall) begin
            hold_d  = imem_rdata;
            state_d = ST_HOLD;
          end else begin
            instr_d = imem_rdata;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + PC_STEP;
            state_d = ST_FETCH;
          end
        end else begin
          // The bus cycle cannot be cancelled: remember the redirect and
          // drop the word when it eventually arrives.
          if (branch_taken) begin
            squash_d  = 1'b1;
            pending_d = branch_target;
          end
`ifdef FETCH_TIMEOUT_EN
          if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
            err_d   = 1'b1;
            req_d   = 1'b0;
            state_d = ST_ERROR;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
`endif
        end
      end

      ST_HOLD: begin
        if (branch_taken) begin
          hold_d  = '0;
          pc_d    = branch_target;
          state_d = ST_FETCH;
        end else if (!stall) begin
          instr_d = hold_q;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_q + PC_STEP;
          state_d = ST_FETCH;
        end
      end

`ifdef FETCH_TIMEOUT_EN
      ST_ERROR: begin
        req_d = 1'b0;
      end
`endif

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  assign imem_req    = req_q;
  assign imem_addr   = addr_q;
  assign instruction = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
`ifdef FETCH_TIMEOUT_EN
  assign fetch_error = err_q;
`else
  assign fetch_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a memory driver issues acks and pushes the
// words that must be delivered; a negedge monitor pops and compares them.
module tb_instruction_fetch;

  localparam int unsigned AW = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          imem_ack = 1'b0;
  logic [31:0]   imem_rdata = '0;
  logic          branch_taken = 1'b0;
  logic [AW-1:0] branch_target = '0;
  logic          stall = 1'b0;

  logic          imem_req, instr_valid, fetch_error;
  logic [AW-1:0] imem_addr, instr_pc;
  logic [31:0]   instruction;

  logic          imem_req2, instr_valid2, fetch_error2;
  logic [AW-1:0] imem_addr2, instr_pc2;
  logic [31:0]   instruction2;

  typedef struct {
    logic [31:0]   data;
    logic [AW-1:0] pc;
  } deliv_t;

  deliv_t exp_q[$];
  int     n_checks = 0;
  int     n_fail   = 0;

  always #5 clock = ~clock;

  instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC('0), .PC_STEP(AW'(1)), .TIMEOUT_CYCLES(16)) dut (
    .clock(clock), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .fetch_error(fetch_error)
  );

  // Second instance starting at all-ones, run in lockstep to see PC wrap.
  instruction_fetch #(.ADDR_WIDTH(AW), .RESET_PC('1), .PC_STEP(AW'(1)), .TIMEOUT_CYCLES(16)) dut_wrap (
    .clock(clock), .reset(reset),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .branch_taken(branch_taken), .branch_target(branch_target), .stall(stall),
    .instruction(instruction2), .instr_pc(instr_pc2), .instr_valid(instr_valid2),
    .fetch_error(fetch_error2)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bounded wait for a request, then check its address.
  task automatic wait_req(input logic [AW-1:0] exp_addr);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    check("req_seen", imem_req, 1);
    check("req_addr", imem_addr, exp_addr);
  endtask

  // Serve one fetch after lat idle WAIT cycles; the word must be delivered.
  task automatic serve(input logic [AW-1:0] addr, input int lat, input logic [31:0] data);
    deliv_t d;
    wait_req(addr);
    for (int i = 0; i < lat; i++) begin
      imem_ack = 1'b0;
      tick();
      check("req_hold", imem_req, 1);
      check("addr_hold", imem_addr, addr);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    d.data = data;
    d.pc   = addr;
    exp_q.push_back(d);
    tick();
    imem_ack = 1'b0;
    check("req_drop", imem_req, 0);
  endtask

  // Monitor: every delivery must match the scoreboard head, else NOP.
  always @(negedge clock) begin
    if (!reset) begin
      if (instr_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_valid", instr_valid, 0);
        end else begin
          deliv_t d;
          d = exp_q.pop_front();
          check("deliv_data", instruction, d.data);
          check("deliv_pc", instr_pc, d.pc);
        end
      end else begin
        check("nop_between", instruction, 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    check("rst_req", imem_req, 0);
    check("rst_addr", imem_addr, 0);
    check("rst_instr", instruction, 0);
    check("rst_ipc", instr_pc, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_err", fetch_error, 0);
    check("rst_addr_wrap", imem_addr2, 32'hFFFF_FFFF);

    // Back-to-back single-cycle acks.
    serve(32'd0, 0, 32'h2000_0000);
    tick();
    check("wrap_addr", imem_addr2, 0);
    serve(32'd1, 0, 32'h2100_0000);

    // Ack delayed three cycles.
    serve(32'd2, 3, 32'h2200_0000);

    // Redirect while waiting: late word is dropped, next fetch at target.
    wait_req(32'd3);
    branch_taken  = 1'b1;
    branch_target = 32'h40;
    tick();
    branch_taken = 1'b0;
    tick();
    check("squash_req_hold", imem_req, 1);
    imem_ack   = 1'b1;
    imem_rdata = 32'h8000_0000;
    tick();
    imem_ack = 1'b0;
    check("squash_valid", instr_valid, 0);

    // Stall for four cycles as the ack returns.
    wait_req(32'h40);
    stall      = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hA400_0000;
    exp_q.push_back('{data: 32'hA400_0000, pc: 32'h40});
    tick();
    imem_ack = 1'b0;
    check("stall_valid", instr_valid, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", instr_valid, 0);
      check("stall_nop", instruction, 0);
    end
    stall = 1'b0;
    tick();
    check("unstall_valid", instr_valid, 1);
    check("unstall_data", instruction, 32'hA400_0000);

    // Branch beats stall on the ack edge.
    wait_req(32'h41);
    imem_ack      = 1'b1;
    stall         = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick();
    imem_ack     = 1'b0;
    stall        = 1'b0;
    branch_taken = 1'b0;
    check("br_stall_valid", instr_valid, 0);
    check("br_stall_req", imem_req, 0);

    // Branch to all-ones, deliver there, next fetch wraps to 0.
    wait_req(32'h100);
    imem_ack      = 1'b1;
    branch_taken  = 1'b1;
    branch_target = 32'hFFFF_FFFF;
    tick();
    imem_ack     = 1'b0;
    branch_taken = 1'b0;
    serve(32'hFFFF_FFFF, 1, 32'h3C00_0000);
    wait_req(32'd0);

    // Never ack this request.
    for (int k = 1; k <= 20; k++) begin
      tick();
`ifdef FETCH_TIMEOUT_EN
      check("to_req", imem_req, (k < 16) ? 1 : 0);
      check("to_err", fetch_error, (k < 16) ? 0 : 1);
`else
      check("to_req", imem_req, 1);
      check("to_err", fetch_error, 0);
`endif
    end

    // Reset mid-transaction aborts, then fetching restarts at RESET_PC.
    reset = 1'b1;
    #1;
    check("rst2_req", imem_req, 0);
    check("rst2_err", fetch_error, 0);
    check("rst2_addr", imem_addr, 0);
    tick();
    reset = 1'b0;
    wait_req(32'd0);
    serve(32'd0, 0, 32'h2300_0000);
    tick();
    tick();

    check("sb_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
